dmem_copy_master: RTL
=====================

Name: dmem_copy_master

Overview:
Bus-master copy engine that drives the data-memory slave port (rd, wr, addr, wdata, rdata, accessable) from the initiator side. It moves a block of 32-bit words from a source word address to a destination word address without CPU involvement. It sits beside the CPU on the data-memory port, with an external arbiter muxing the two masters. It reports completion and address faults back to the system.

Parameters:
LEN_W, 16, width of the word-count register; maximum transfer is 2^LEN_W-1 words.

Ports:
clk  in  1  system clock; all state changes on posedge.
reset_n  in  1  synchronous active-low reset, sampled on posedge clk.
start  in  1  one-cycle request; sampled only in IDLE.
src_addr  in  32  source word address, latched on accepted start.
dst_addr  in  32  destination word address, latched on accepted start.
len  in  LEN_W  number of words to copy, latched on accepted start.
fill  in  1  fill-mode select, latched on accepted start (see Optional Feature).
fill_val  in  32  fill pattern, latched on accepted start.
busy  out  1  high from the cycle after an accepted start until DONE/ERR is entered.
done  out  1  one-cycle pulse on successful completion.
err  out  1  sticky fault flag; cleared by the next accepted start or by reset.
err_addr  out  32  address presented when accessable was seen low.
mem_rd  out  1  data-memory read strobe.
mem_wr  out  1  data-memory write strobe.
mem_addr  out  32  data-memory word address.
mem_wdata  out  32  data-memory write data.
mem_rdata  in  32  data-memory read data, combinational and valid in the same cycle as mem_rd.
mem_accessable  in  1  0 means the current rd/wr address is invalid.

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE. busy=0, done=0, err=0, err_addr=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0. Internal count, pointers and data buffer are cleared to 0.
- Reset mid-transfer: abort at that edge with no further strobes. A word written before the reset edge stays written.
- mem_rd, mem_wr, mem_addr and mem_wdata are decoded combinationally from the registered state and pointers, so they are glitch-free per cycle.
- State machine: IDLE, RD, WR, DONE, ERR.
  - IDLE: start=1 latches src, dst, len and fill; clears err.
    - len=0: go to DONE (no memory access).
    - Otherwise: go to RD, or to WR if fill mode is active.
    - start in any state other than IDLE is ignored.
  - RD: mem_rd=1, mem_addr=src_ptr.
    - mem_accessable=0: err_addr<=src_ptr, go to ERR.
    - Otherwise: buffer<=mem_rdata, go to WR.
  - WR: mem_wr=1, mem_addr=dst_ptr, mem_wdata=buffer (or fill pattern).
    - mem_accessable=0: err_addr<=dst_ptr, go to ERR.
    - Otherwise: src_ptr+=1, dst_ptr+=1, count-=1. Go to DONE if count was 1; else go to RD (or WR in fill mode).
  - DONE: done=1 for exactly this cycle, busy=0, go to IDLE.
  - ERR: err<=1 (sticky), busy=0, go to IDLE. No done pulse. Remaining words are not transferred.
- Throughput: 2 cycles per word in copy mode, 1 cycle per word in fill mode. Latency from start to done for N≥1 words is 2N+1 cycles (copy) or N+1 cycles (fill).
- Addresses are word indices. Pointer increment wraps modulo 2^32 with no fault of its own; a fault is raised only via mem_accessable.
- Copy is always ascending. For overlapping regions with dst>src, the result is defined as the sequential ascending copy (source words may already be overwritten).
- mem_rd and mem_wr are never high in the same cycle.

Optional Feature:
Macro DMEM_COPY_FILL_EN.
- Defined: a latched fill=1 skips RD entirely. Each WR writes the latched fill_val.
- Undefined: the fill and fill_val ports remain present but are ignored; every transfer is a copy. No fill-datapath logic is synthesized.

Test Plan:
- Copy, 4 words: preload mem[0..3]=A0,A1,A2,A3; start src=0, dst=16, len=4 -> mem[16..19]=A0..A3; done pulse exactly 9 cycles after the start edge; busy high 8 cycles; err=0.
- len=0: start src=5, dst=9, len=0 -> done pulses on the next cycle; mem_rd and mem_wr never asserted.
- Read fault: RAM_SIZE=256; start src=254, dst=0, len=4 -> words 254 and 255 copied to 0 and 1; err=1; err_addr=256; no done pulse; mem[2] unchanged.
- Write fault, then recovery: start src=0, dst=255, len=2 -> err=1, err_addr=256. A following good start (src=0, dst=32, len=1) clears err and completes with done.
- Reset and busy-ignore: start src=0, dst=64, len=8; pulse start again in cycle 3 -> ignored. Assert reset_n=0 in cycle 6 -> all outputs 0 the next cycle; only mem[64..66] written.
- With DMEM_COPY_FILL_EN defined: start fill=1, fill_val=0xDEADBEEF, dst=100, len=3 -> mem[100..102]=0xDEADBEEF; mem_rd never high; done 4 cycles after start. Without the macro, the same stimulus performs a copy.

Source files
------------

// File: rtl/dmem_copy_master.sv
// rtl/dmem_copy_master.sv - block copy bus master for the data-memory port
// Optional fill mode (write a latched pattern, no reads): DMEM_COPY_FILL_EN
module dmem_copy_master #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic             fill,
  input  logic [31:0]      fill_val,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      err_addr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_accessable
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_ERR} state_t;

  state_t           state, state_nx;
  logic [31:0]      src_ptr, dst_ptr, buffer;
  logic [LEN_W-1:0] count;
  logic             fill_req;
  logic             fill_mode;
  logic [31:0]      wr_word;

`ifdef DMEM_COPY_FILL_EN
  logic        fill_q;
  logic [31:0] fill_val_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fill_q     <= 1'b0;
      fill_val_q <= 32'h0;
    end else if (state == S_IDLE && start) begin
      fill_q     <= fill;
      fill_val_q <= fill_val;
    end
  end

  assign fill_req  = fill;
  assign fill_mode = fill_q;
  assign wr_word   = fill_q ? fill_val_q : buffer;
`else
  // fill inputs exist for pin compatibility only
  logic unused_fill;
  assign unused_fill = ^{fill, fill_val};
  assign fill_req    = 1'b0;
  assign fill_mode   = 1'b0;
  assign wr_word     = buffer;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      src_ptr  <= 32'h0;
      dst_ptr  <= 32'h0;
      count    <= '0;
      buffer   <= 32'h0;
      err      <= 1'b0;
      err_addr <= 32'h0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          src_ptr <= src_addr;
          dst_ptr <= dst_addr;
          count   <= len;
          err     <= 1'b0;
        end
        S_RD: begin
          if (mem_accessable) buffer <= mem_rdata;
          else                err_addr <= src_ptr;
        end
        S_WR: begin
          if (mem_accessable) begin
            src_ptr <= src_ptr + 32'd1;
            dst_ptr <= dst_ptr + 32'd1;
            count   <= count - LEN_W'(1);
          end else begin
            err_addr <= dst_ptr;
          end
        end
        S_ERR:   err <= 1'b1;
        default: ;
      endcase
    end
  end

  // Strobes are pure decodes of registered state so they cannot glitch within a cycle
  always_comb begin
    state_nx  = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len == '0)    state_nx = S_DONE;
          else if (fill_req) state_nx = S_WR;
          else               state_nx = S_RD;
        end
      end
      S_RD: begin
        mem_rd   = 1'b1;
        mem_addr = src_ptr;
        state_nx = mem_accessable ? S_WR : S_ERR;
      end
      S_WR: begin
        mem_wr    = 1'b1;
        mem_addr  = dst_ptr;
        mem_wdata = wr_word;
        if (!mem_accessable)          state_nx = S_ERR;
        else if (count == LEN_W'(1))  state_nx = S_DONE;
        else if (fill_mode)           state_nx = S_WR;
        else                          state_nx = S_RD;
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state == S_RD) || (state == S_WR);
  assign done = (state == S_DONE);

endmodule
